// File: rtl/seg_scan_if.sv
// Front-panel bus for seg_scan: captured BCD pairs, load/blank/blink controls and
// the active-low digit-enable and segment outputs.
interface seg_scan_if;
    logic [7:0] bcd_a;
    logic [7:0] bcd_b;
    logic       load;
    logic       blank_lz;
    logic       blink;
    logic [3:0] an;
    logic [6:0] seg;

    modport master (
        output bcd_a, bcd_b, load, blank_lz, blink,
        input  an, seg
    );

    modport slave (
        input  bcd_a, bcd_b, load, blank_lz, blink,
        output an, seg
    );
endinterface

// File: rtl/seg_scan.sv
// Four-digit multiplexed common-anode seven-segment driver with leading-zero blanking.
// Optional display blinking is built only when SEG_SCAN_BLINK_EN is defined.
module seg_scan #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    idx;
    logic [7:0]    sh_a;
    logic [7:0]    sh_b;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;

    assign tick = (cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a <= '0;
            sh_b <= '0;
        end else if (bus.load) begin
            sh_a <= bus.bcd_a;
            sh_b <= bus.bcd_b;
        end
    end

    // Odd indices are tens digits; only those are eligible for zero blanking.
    always_comb begin
        nib = '0;
        unique case (idx)
            2'd0: nib = sh_a[3:0];
            2'd1: nib = sh_a[7:4];
            2'd2: nib = sh_b[3:0];
            2'd3: nib = sh_b[7:4];
        endcase
        blank = bus.blank_lz && idx[0] && (nib == 4'd0);
    end

    always_comb begin
        seg_d = 7'b0111111;
        if (blank) begin
            seg_d = '1;
        end else begin
            case (nib)
                4'd0: seg_d = 7'b1000000;
                4'd1: seg_d = 7'b1111001;
                4'd2: seg_d = 7'b0100100;
                4'd3: seg_d = 7'b0110000;
                4'd4: seg_d = 7'b0011001;
                4'd5: seg_d = 7'b0010010;
                4'd6: seg_d = 7'b0000010;
                4'd7: seg_d = 7'b1111000;
                4'd8: seg_d = 7'b0000000;
                4'd9: seg_d = 7'b0010000;
                default: seg_d = 7'b0111111;
            endcase
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] bcnt;
    logic          phase;

    // Phase advances on scan ticks regardless of the blink request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (tick) begin
            if (bcnt == BW'(BLINK_DIV - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    always_comb begin
        an_d = ~(4'b0001 << idx);
        if (bus.blink && !phase) begin
            an_d = '1;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = bus.blink;

    always_comb begin
        an_d = ~(4'b0001 << idx);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.an  <= '1;
            bus.seg <= '1;
        end else begin
            bus.an  <= an_d;
            bus.seg <= seg_d;
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: a per-edge reference derived from the scan
// timing pushes expected an/seg into a scoreboard that each scenario pops and checks.
module tb_seg_scan;
    localparam int unsigned SD = 4;
    localparam int unsigned BD = 2;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_scan_if bus ();

    seg_scan #(
        .SCAN_DIV (SD),
        .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned k;
    logic [7:0]  m_a;
    logic [7:0]  m_b;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Edge kk (1-based since reset release) shows digit ((kk-1)/SD)%4.
    function automatic logic [3:0] exp_an(input int unsigned kk, input logic bl);
        int unsigned d;
        logic [3:0]  a;
        d = ((kk - 1) / SD) % 4;
        a = ~(4'b0001 << d);
`ifdef SEG_SCAN_BLINK_EN
        if (bl && ((((kk - 1) / (SD * BD)) % 2) == 1)) a = 4'b1111;
`endif
        return a;
    endfunction

    function automatic logic [6:0] exp_seg(input int unsigned kk, input logic [7:0] a,
                                           input logic [7:0] b, input logic blz);
        int unsigned d;
        logic [3:0]  n;
        d = ((kk - 1) / SD) % 4;
        case (d)
            0: n = a[3:0];
            1: n = a[7:4];
            2: n = b[3:0];
            default: n = b[7:4];
        endcase
        if ((d % 2 == 1) && blz && (n == 4'd0)) return 7'b1111111;
        return dec(n);
    endfunction

    // Drive one cycle of stimulus and queue the output expected after the next edge.
    task automatic advance(input logic ld, input logic [7:0] a, input logic [7:0] b,
                           input logic blz, input logic bl);
        exp_t e;
        bus.load     = ld;
        bus.bcd_a    = a;
        bus.bcd_b    = b;
        bus.blank_lz = blz;
        bus.blink    = bl;
        e.an  = exp_an(k + 1, bl);
        e.seg = exp_seg(k + 1, m_a, m_b, blz);
        sb.push_back(e);
        @(posedge clk);
        k = k + 1;
        if (ld) begin
            m_a = a;
            m_b = b;
        end
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        m_a = 8'h00;
        m_b = 8'h00;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.bcd_a    = 8'h00;
        bus.bcd_b    = 8'h00;
        bus.blank_lz = 1'b0;
        bus.blink    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.an, bus.seg} !== {4'b1111, 7'b1111111}) begin
            n_fail++;
            $display("FAIL reset_hold: an=%b seg=%b required an=1111 seg=1111111", bus.an, bus.seg);
        end
        release_reset();
        for (int i = 0; i < 32; i++) begin
            advance(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if ({bus.an, bus.seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL reset_scan k=%0d: an=%b seg=%b required an=%b seg=%b",
                         k, bus.an, bus.seg, e.an, e.seg);
            end
            if (k == 1 || k == 17) begin
                n_checks++;
                if ({bus.an, bus.seg} !== {4'b1110, 7'b1000000}) begin
                    n_fail++;
                    $display("FAIL frame_start k=%0d: an=%b seg=%b required an=1110 seg=1000000",
                             k, bus.an, bus.seg);
                end
            end
        end
    endtask

    task automatic test_blank_lz();
        exp_t e;
        for (int i = 0; i < 18; i++) begin
            advance(i == 0, 8'h37, 8'h05, 1'b1, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if ({bus.an, bus.seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL blank_lz k=%0d: an=%b seg=%b required an=%b seg=%b",
                         k, bus.an, bus.seg, e.an, e.seg);
            end
            if (i > 1 && bus.an == 4'b0111) begin
                n_checks++;
                if (bus.seg !== 7'b1111111) begin
                    n_fail++;
                    $display("FAIL blank_tens: seg=%b required 1111111", bus.seg);
                end
            end
        end
    endtask

    task automatic test_no_blank_dash();
        exp_t e;
        for (int i = 0; i < 36; i++) begin
            advance(i == 18, 8'h37, (i >= 18) ? 8'hA9 : 8'h05, 1'b0, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if ({bus.an, bus.seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL no_blank_dash k=%0d: an=%b seg=%b required an=%b seg=%b",
                         k, bus.an, bus.seg, e.an, e.seg);
            end
            if (i > 20 && bus.an == 4'b0111) begin
                n_checks++;
                if (bus.seg !== 7'b0111111) begin
                    n_fail++;
                    $display("FAIL dash: seg=%b required 0111111", bus.seg);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        advance(1'b1, 8'h58, 8'h62, 1'b0, 1'b0);
        advance(1'b0, 8'h58, 8'h62, 1'b0, 1'b0);
        sb.delete();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.an, bus.seg} !== {4'b1111, 7'b1111111}) begin
            n_fail++;
            $display("FAIL async_reset: an=%b seg=%b required an=1111 seg=1111111", bus.an, bus.seg);
        end
        release_reset();
        for (int i = 0; i < 20; i++) begin
            advance(1'b0, 8'h58, 8'h62, 1'b0, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if ({bus.an, bus.seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL after_reset k=%0d: an=%b seg=%b required an=%b seg=%b",
                         k, bus.an, bus.seg, e.an, e.seg);
            end
        end
    endtask

    task automatic test_load_latency();
        exp_t e;
        rst = 1'b1;
        #1;
        release_reset();
        for (int i = 0; i < 6; i++) begin
            advance(i == 1, 8'h08, 8'h00, 1'b0, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if ({bus.an, bus.seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL load_latency k=%0d: an=%b seg=%b required an=%b seg=%b",
                         k, bus.an, bus.seg, e.an, e.seg);
            end
            if (k == 2 || k == 3) begin
                n_checks++;
                if ({bus.an, bus.seg} !== {4'b1110, (k == 2) ? 7'b1000000 : 7'b0000000}) begin
                    n_fail++;
                    $display("FAIL load_edge k=%0d: an=%b seg=%b required an=1110 seg=%b",
                             k, bus.an, bus.seg, (k == 2) ? 7'b1000000 : 7'b0000000);
                end
            end
        end
    endtask

    task automatic test_load_on_tick();
        exp_t e;
        int   n;
        n = 0;
        while (k % SD != SD - 1 && n < 8) begin
            advance(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            void'(sb.pop_front());
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            advance(i == 0, 8'h21, 8'h43, 1'b1, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if ({bus.an, bus.seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL load_on_tick k=%0d: an=%b seg=%b required an=%b seg=%b",
                         k, bus.an, bus.seg, e.an, e.seg);
            end
        end
    endtask

    task automatic test_blink();
        exp_t e;
        for (int i = 0; i < 36; i++) begin
            advance(1'b0, 8'h00, 8'h00, 1'b0, i < 32);
            e = sb.pop_front();
            n_checks++;
            if ({bus.an, bus.seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL blink k=%0d: an=%b seg=%b required an=%b seg=%b",
                         k, bus.an, bus.seg, e.an, e.seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blank_lz();
        test_no_blank_dash();
        test_async_reset();
        test_load_latency();
        test_load_on_tick();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
